// File: rtl/zap_cache_fsm_if.sv
// CPU, cache RAM and Wishbone signals of the cache controller, named from the controller's side.
// master = controller; slave = CPU/RAM/bus environment driving the i_* side.
interface zap_cache_fsm_if #(
  parameter int TAG_WDT = 28
);
  // CPU side
  logic               i_rd;
  logic               i_wr;
  logic [31:0]        i_address;
  logic [3:0]         i_ben;
  logic [31:0]        i_dat;
  logic [31:0]        o_dat;
  logic               o_ack;
  logic               o_stall;

  // Tag/data RAM side
  logic [31:0]        o_address_nxt;
  logic [31:0]        o_address;
  logic [127:0]       i_cache_line;
  logic [TAG_WDT-1:0] i_cache_tag;
  logic               i_cache_tag_valid;
  logic               i_cache_tag_dirty;
  logic [127:0]       o_cache_line;
  logic [15:0]        o_cache_line_ben;
  logic               o_cache_tag_wr_en;
  logic [TAG_WDT-1:0] o_cache_tag;
  logic               o_cache_tag_dirty;

  // Wishbone master side
  logic               o_wb_cyc;
  logic               o_wb_stb;
  logic               o_wb_wen;
  logic [31:0]        o_wb_adr;
  logic [31:0]        o_wb_dat;
  logic [3:0]         o_wb_sel;
  logic [2:0]         o_wb_cti;
  logic               i_wb_ack;
  logic [31:0]        i_wb_dat;

  modport master (
    input  i_rd, i_wr, i_address, i_ben, i_dat,
    input  i_cache_line, i_cache_tag, i_cache_tag_valid, i_cache_tag_dirty,
    input  i_wb_ack, i_wb_dat,
    output o_dat, o_ack, o_stall, o_address_nxt, o_address,
    output o_cache_line, o_cache_line_ben, o_cache_tag_wr_en, o_cache_tag, o_cache_tag_dirty,
    output o_wb_cyc, o_wb_stb, o_wb_wen, o_wb_adr, o_wb_dat, o_wb_sel, o_wb_cti
  );

  modport slave (
    output i_rd, i_wr, i_address, i_ben, i_dat,
    output i_cache_line, i_cache_tag, i_cache_tag_valid, i_cache_tag_dirty,
    output i_wb_ack, i_wb_dat,
    input  o_dat, o_ack, o_stall, o_address_nxt, o_address,
    input  o_cache_line, o_cache_line_ben, o_cache_tag_wr_en, o_cache_tag, o_cache_tag_dirty,
    input  o_wb_cyc, o_wb_stb, o_wb_wen, o_wb_adr, o_wb_dat, o_wb_sel, o_wb_cti
  );
endinterface

// File: rtl/zap_cache_fsm.sv
// Direct-mapped cache controller: hit read/write, dirty-victim write-back and 4-beat Wishbone line fill.
// Hit ack 2 cycles after request; misses stall (o_stall) for the full burst; Wishbone wait states simply hold the beat.
module zap_cache_fsm #(
  parameter int CACHE_SIZE = 1024,
  parameter int TAG_WDT    = 28
) (
  input  logic            i_clk,
  input  logic            i_reset,
  zap_cache_fsm_if.master bus
);
  localparam int INDEX_W = $clog2(CACHE_SIZE / 16);

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    EVICT,
    FILL,
    LINE_WR,
    REPLAY
  } state_t;

  typedef struct packed {
    logic [31:0] adr;
    logic [3:0]  ben;
    logic [31:0] dat;
    logic        wr;
  } req_t;

  state_t             state;
  req_t               req_q;
  logic [1:0]         beat;
  logic [1:0]         beat_nxt;
  logic [127:0]       buffer;
  logic [127:0]       fill_line;
  logic [TAG_WDT-1:0] req_tag;
  logic               hit;
  logic [31:0]        rd_word;
  logic [31:0]        victim_base;
  logic [31:0]        fill_base;
  logic               wb_take;

  assign req_tag   = TAG_WDT'(req_q.adr[31:4]);
  assign hit       = bus.i_cache_tag_valid && (bus.i_cache_tag == req_tag);
  assign rd_word   = bus.i_cache_line[{req_q.adr[3:2], 5'd0} +: 32];
  assign beat_nxt  = beat + 2'd1;
  assign wb_take   = bus.i_wb_ack && bus.o_wb_stb;
  assign fill_base = {req_q.adr[31:4], 4'b0000};

  // Victim shares the request's set, so only the upper tag bits come from the RAM.
  assign victim_base = 32'({bus.i_cache_tag[TAG_WDT-1:INDEX_W], req_q.adr[4 +: INDEX_W], 4'b0000});

  always_comb begin
    fill_line = buffer;
    fill_line[{beat, 5'd0} +: 32] = bus.i_wb_dat;
  end

  assign bus.o_address     = req_q.adr;
  assign bus.o_address_nxt = (state == IDLE) ? bus.i_address : req_q.adr;
  assign bus.o_stall       = (state != IDLE) && !bus.o_ack;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state                 <= IDLE;
      req_q                 <= '0;
      beat                  <= 2'd0;
      buffer                <= '0;
      bus.o_ack             <= 1'b0;
      bus.o_dat             <= '0;
      bus.o_cache_tag_wr_en <= 1'b0;
      bus.o_cache_line_ben  <= '0;
      bus.o_cache_line      <= '0;
      bus.o_cache_tag       <= '0;
      bus.o_cache_tag_dirty <= 1'b0;
      bus.o_wb_cyc          <= 1'b0;
      bus.o_wb_stb          <= 1'b0;
      bus.o_wb_wen          <= 1'b0;
      bus.o_wb_sel          <= '0;
      bus.o_wb_adr          <= '0;
      bus.o_wb_dat          <= '0;
      bus.o_wb_cti          <= 3'b000;
    end else begin
      bus.o_ack             <= 1'b0;
      bus.o_cache_tag_wr_en <= 1'b0;
      bus.o_cache_line_ben  <= '0;

      case (state)
        IDLE: begin
          // The CPU still holds the finished request during the ack cycle.
          if ((bus.i_rd || bus.i_wr) && !bus.o_ack) begin
            req_q <= '{adr: bus.i_address, ben: bus.i_ben, dat: bus.i_dat, wr: bus.i_wr};
            state <= COMPARE;
          end
        end

        COMPARE: begin
          if (hit) begin
            bus.o_ack <= 1'b1;
            state     <= IDLE;
            if (req_q.wr) begin
              bus.o_cache_tag_wr_en <= 1'b1;
              bus.o_cache_tag       <= req_tag;
              bus.o_cache_tag_dirty <= 1'b1;
              bus.o_cache_line      <= {4{req_q.dat}};
              bus.o_cache_line_ben  <= 16'(req_q.ben) << {req_q.adr[3:2], 2'b00};
            end else begin
              bus.o_dat <= rd_word;
            end
          end else if (bus.i_cache_tag_valid && bus.i_cache_tag_dirty) begin
            state        <= EVICT;
            beat         <= 2'd0;
            bus.o_wb_cyc <= 1'b1;
            bus.o_wb_stb <= 1'b1;
            bus.o_wb_wen <= 1'b1;
            bus.o_wb_sel <= 4'hF;
            bus.o_wb_adr <= victim_base;
            bus.o_wb_dat <= bus.i_cache_line[31:0];
            bus.o_wb_cti <= 3'b010;
          end else begin
            state <= FILL;
            beat  <= 2'd0;
          end
        end

        EVICT: begin
          if (wb_take) begin
            if (beat == 2'd3) begin
              beat         <= 2'd0;
              state        <= FILL;
              bus.o_wb_cyc <= 1'b0;
              bus.o_wb_stb <= 1'b0;
              bus.o_wb_wen <= 1'b0;
              bus.o_wb_sel <= '0;
              bus.o_wb_cti <= 3'b000;
            end else begin
              beat         <= beat_nxt;
              bus.o_wb_adr <= bus.o_wb_adr + 32'd4;
              bus.o_wb_dat <= bus.i_cache_line[{beat_nxt, 5'd0} +: 32];
              bus.o_wb_cti <= (beat_nxt == 2'd3) ? 3'b111 : 3'b010;
            end
          end
        end

        FILL: begin
          // FILL is always entered with the bus idle; the first cycle launches the burst.
          if (!bus.o_wb_stb) begin
            beat         <= 2'd0;
            bus.o_wb_cyc <= 1'b1;
            bus.o_wb_stb <= 1'b1;
            bus.o_wb_wen <= 1'b0;
            bus.o_wb_sel <= 4'hF;
            bus.o_wb_adr <= fill_base;
            bus.o_wb_dat <= '0;
            bus.o_wb_cti <= 3'b010;
          end else if (wb_take) begin
            buffer <= fill_line;
            if (beat == 2'd3) begin
              beat                  <= 2'd0;
              state                 <= LINE_WR;
              bus.o_wb_cyc          <= 1'b0;
              bus.o_wb_stb          <= 1'b0;
              bus.o_wb_sel          <= '0;
              bus.o_wb_cti          <= 3'b000;
              bus.o_cache_tag_wr_en <= 1'b1;
              bus.o_cache_tag       <= req_tag;
              bus.o_cache_tag_dirty <= 1'b0;
              bus.o_cache_line      <= fill_line;
              bus.o_cache_line_ben  <= 16'hFFFF;
            end else begin
              beat         <= beat_nxt;
              bus.o_wb_adr <= bus.o_wb_adr + 32'd4;
              bus.o_wb_cti <= (beat_nxt == 2'd3) ? 3'b111 : 3'b010;
            end
          end
        end

        LINE_WR: state <= REPLAY;

        // Bubble so the RAM read sees the freshly written line.
        REPLAY: state <= COMPARE;

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_zap_cache_fsm.sv
// Directed bench for zap_cache_fsm with a read-first tag/data RAM model and a Wishbone memory model.
module tb_zap_cache_fsm;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  zap_cache_fsm_if #(.TAG_WDT(28)) bus ();

  zap_cache_fsm #(.CACHE_SIZE(1024), .TAG_WDT(28)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int checks = 0;
  int passed = 0;

  logic         tb_init;
  logic [127:0] ram_line [0:63];
  logic [27:0]  ram_tag  [0:63];
  logic         ram_v    [0:63];
  logic         ram_d    [0:63];
  logic [31:0]  mem      [0:4095];

  logic [31:0]  log_adr[$];
  logic [31:0]  log_dat[$];
  logic [2:0]   log_cti[$];
  logic         log_wen[$];
  logic [127:0] rw_line[$];
  logic [15:0]  rw_ben[$];
  logic         rw_dirty[$];

  logic hold_arm;
  int   hold_cnt;
  int   b1_cycles;
  logic on_b1, hold, wb_ack;
  logic [5:0] rd_idx, wr_idx;

  assign on_b1 = bus.o_wb_cyc && bus.o_wb_stb && !bus.o_wb_wen && (bus.o_wb_adr == 32'h0000_1404);
  assign hold  = hold_arm && on_b1 && (hold_cnt < 3);
  assign wb_ack = bus.o_wb_cyc && bus.o_wb_stb && !hold;
  assign bus.i_wb_ack = wb_ack;
  assign bus.i_wb_dat = mem[bus.o_wb_adr[13:2]];
  assign rd_idx = bus.o_address_nxt[9:4];
  assign wr_idx = bus.o_address[9:4];

  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 64; i++) begin
        ram_line[i] <= '0;
        ram_tag[i]  <= '0;
        ram_v[i]    <= 1'b0;
        ram_d[i]    <= 1'b0;
      end
      for (int i = 0; i < 4096; i++) mem[i] <= 32'h0;
      mem[12'h400] <= 32'h11; mem[12'h401] <= 32'h22; mem[12'h402] <= 32'h33; mem[12'h403] <= 32'h44;
      mem[12'h500] <= 32'h55; mem[12'h501] <= 32'h66; mem[12'h502] <= 32'h77; mem[12'h503] <= 32'h88;
      mem[12'h600] <= 32'h99; mem[12'h601] <= 32'hAA; mem[12'h602] <= 32'hBB; mem[12'h603] <= 32'hCC;
      bus.i_cache_line      <= '0;
      bus.i_cache_tag       <= '0;
      bus.i_cache_tag_valid <= 1'b0;
      bus.i_cache_tag_dirty <= 1'b0;
      hold_cnt  <= 0;
      b1_cycles <= 0;
    end else begin
      // Read-first RAM: a write and a read of the same set in one edge returns the old line.
      bus.i_cache_line      <= ram_line[rd_idx];
      bus.i_cache_tag       <= ram_tag[rd_idx];
      bus.i_cache_tag_valid <= ram_v[rd_idx];
      bus.i_cache_tag_dirty <= ram_d[rd_idx];
      if (bus.o_cache_tag_wr_en) begin
        for (int b = 0; b < 16; b++)
          if (bus.o_cache_line_ben[b]) ram_line[wr_idx][8*b +: 8] <= bus.o_cache_line[8*b +: 8];
        ram_tag[wr_idx] <= bus.o_cache_tag;
        ram_v[wr_idx]   <= 1'b1;
        ram_d[wr_idx]   <= bus.o_cache_tag_dirty;
        rw_line.push_back(bus.o_cache_line);
        rw_ben.push_back(bus.o_cache_line_ben);
        rw_dirty.push_back(bus.o_cache_tag_dirty);
      end
      if (wb_ack) begin
        if (bus.o_wb_wen) mem[bus.o_wb_adr[13:2]] <= bus.o_wb_dat;
        log_adr.push_back(bus.o_wb_adr);
        log_dat.push_back(bus.o_wb_wen ? bus.o_wb_dat : bus.i_wb_dat);
        log_cti.push_back(bus.o_wb_cti);
        log_wen.push_back(bus.o_wb_wen);
      end
      if (!hold_arm) begin
        hold_cnt  <= 0;
        b1_cycles <= 0;
      end else if (on_b1) begin
        b1_cycles <= b1_cycles + 1;
        if (hold) hold_cnt <= hold_cnt + 1;
      end
    end
  end

  // Issue one access at posedge+1 and wait for o_ack; leaves one idle cycle afterwards.
  task automatic do_access(input logic wr, input logic [31:0] adr, input logic [3:0] ben,
                           input logic [31:0] dat, output logic [31:0] rdat, output int lat,
                           output logic twe, output logic [15:0] tben, output logic tdirty);
    logic got = 1'b0;
    rdat = '0; lat = 0; twe = 1'b0; tben = '0; tdirty = 1'b0;
    bus.i_rd = !wr; bus.i_wr = wr; bus.i_address = adr; bus.i_ben = ben; bus.i_dat = dat;
    while (!got && lat < 300) begin
      @(posedge clk); #1;
      lat++;
      if (bus.o_ack) begin
        got = 1'b1; rdat = bus.o_dat;
        twe = bus.o_cache_tag_wr_en; tben = bus.o_cache_line_ben; tdirty = bus.o_cache_tag_dirty;
      end
    end
    bus.i_rd = 1'b0; bus.i_wr = 1'b0;
    checks++;
    if (got !== 1'b1) $display("FAIL access_ack adr=%h: no o_ack after %0d cycles", adr, lat);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; tb_init = 1'b1; hold_arm = 1'b0;
    bus.i_rd = 1'b0; bus.i_wr = 1'b0; bus.i_address = '0; bus.i_ben = '0; bus.i_dat = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.o_ack, bus.o_stall, bus.o_wb_cyc, bus.o_wb_stb, bus.o_wb_wen, bus.o_cache_tag_wr_en} !== 6'b0)
      $display("FAIL reset_ctl: got %b required 000000", {bus.o_ack, bus.o_stall, bus.o_wb_cyc,
               bus.o_wb_stb, bus.o_wb_wen, bus.o_cache_tag_wr_en});
    else passed++;
    checks++;
    if ({bus.o_wb_sel, bus.o_wb_cti, bus.o_cache_line_ben} !== 23'b0)
      $display("FAIL reset_sel_cti_ben: got %h/%b/%h required 0", bus.o_wb_sel, bus.o_wb_cti, bus.o_cache_line_ben);
    else passed++;
    checks++;
    if ({bus.o_wb_adr, bus.o_wb_dat, bus.o_dat} !== 96'b0)
      $display("FAIL reset_data: adr=%h dat=%h o_dat=%h required 0", bus.o_wb_adr, bus.o_wb_dat, bus.o_dat);
    else passed++;
    rst = 1'b0; tb_init = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_cold_read();
    logic [31:0] rd; int lat; logic twe; logic [15:0] tben; logic td;
    int b0 = log_adr.size();
    int w0 = rw_ben.size();
    do_access(1'b0, 32'h0000_1004, 4'h0, 32'h0, rd, lat, twe, tben, td);
    checks++;
    if (rd !== 32'h22) $display("FAIL cold_read_dat: got %h required 00000022", rd); else passed++;
    checks++;
    if (log_adr.size() - b0 !== 4) $display("FAIL cold_read_beats: got %0d required 4", log_adr.size() - b0);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({log_adr[b0+i], log_cti[b0+i], log_wen[b0+i]} !== {32'h1000 + 32'(4*i), (i == 3) ? 3'b111 : 3'b010, 1'b0})
        $display("FAIL cold_read_beat%0d: adr=%h cti=%b wen=%b required adr=%h", i,
                 log_adr[b0+i], log_cti[b0+i], log_wen[b0+i], 32'h1000 + 32'(4*i));
      else passed++;
    end
    checks++;
    if ({rw_ben.size() - w0, rw_ben[w0], rw_dirty[w0]} !== {32'd1, 16'hFFFF, 1'b0})
      $display("FAIL cold_read_line_wr: writes=%0d ben=%h dirty=%b required 1/ffff/0",
               rw_ben.size() - w0, rw_ben[w0], rw_dirty[w0]);
    else passed++;
    checks++;
    if (rw_line[w0] !== {32'h44, 32'h33, 32'h22, 32'h11})
      $display("FAIL cold_read_line_dat: got %h", rw_line[w0]);
    else passed++;
  endtask

  task automatic test_read_hit();
    logic [31:0] rd; int lat; logic twe; logic [15:0] tben; logic td;
    int b0 = log_adr.size();
    do_access(1'b0, 32'h0000_1008, 4'h0, 32'h0, rd, lat, twe, tben, td);
    checks++;
    if ({lat, rd} !== {32'd2, 32'h33}) $display("FAIL read_hit: lat=%0d dat=%h required 2/00000033", lat, rd);
    else passed++;
    checks++;
    if (log_adr.size() !== b0) $display("FAIL read_hit_wb: got %0d beats required 0", log_adr.size() - b0);
    else passed++;
  endtask

  task automatic test_write_hit();
    logic [31:0] rd; int lat; logic twe; logic [15:0] tben; logic td;
    int b0 = log_adr.size();
    do_access(1'b1, 32'h0000_1008, 4'b0011, 32'hAAAA_BBBB, rd, lat, twe, tben, td);
    checks++;
    if ({lat, twe, tben, td} !== {32'd2, 1'b1, 16'h0300, 1'b1})
      $display("FAIL write_hit: lat=%0d wr_en=%b ben=%h dirty=%b required 2/1/0300/1", lat, twe, tben, td);
    else passed++;
    do_access(1'b0, 32'h0000_1008, 4'h0, 32'h0, rd, lat, twe, tben, td);
    checks++;
    if ({lat, rd} !== {32'd2, 32'h0000_BBBB})
      $display("FAIL write_hit_readback: lat=%0d dat=%h required 2/0000bbbb", lat, rd);
    else passed++;
    checks++;
    if (log_adr.size() !== b0) $display("FAIL write_hit_wb: got %0d beats required 0", log_adr.size() - b0);
    else passed++;
  endtask

  task automatic test_evict_fill_wait();
    logic [31:0] rd; int lat; logic twe; logic [15:0] tben; logic td;
    logic [31:0] exp_ev [4] = '{32'h11, 32'h22, 32'h0000_BBBB, 32'h44};
    logic [31:0] exp_fl [4] = '{32'h55, 32'h66, 32'h77, 32'h88};
    int b0 = log_adr.size();
    hold_arm = 1'b1;
    do_access(1'b0, 32'h0000_1408, 4'h0, 32'h0, rd, lat, twe, tben, td);
    checks++;
    if (rd !== 32'h77) $display("FAIL evict_read_dat: got %h required 00000077", rd); else passed++;
    checks++;
    if (log_adr.size() - b0 !== 8) $display("FAIL evict_fill_beats: got %0d required 8", log_adr.size() - b0);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({log_adr[b0+i], log_dat[b0+i], log_cti[b0+i], log_wen[b0+i]} !==
          {32'h1000 + 32'(4*i), exp_ev[i], (i == 3) ? 3'b111 : 3'b010, 1'b1})
        $display("FAIL evict_beat%0d: adr=%h dat=%h cti=%b wen=%b required %h/%h", i, log_adr[b0+i],
                 log_dat[b0+i], log_cti[b0+i], log_wen[b0+i], 32'h1000 + 32'(4*i), exp_ev[i]);
      else passed++;
      checks++;
      if ({log_adr[b0+4+i], log_dat[b0+4+i], log_cti[b0+4+i], log_wen[b0+4+i]} !==
          {32'h1400 + 32'(4*i), exp_fl[i], (i == 3) ? 3'b111 : 3'b010, 1'b0})
        $display("FAIL fill_beat%0d: adr=%h dat=%h cti=%b wen=%b required %h/%h", i, log_adr[b0+4+i],
                 log_dat[b0+4+i], log_cti[b0+4+i], log_wen[b0+4+i], 32'h1400 + 32'(4*i), exp_fl[i]);
      else passed++;
    end
    checks++;
    if (b1_cycles !== 4) $display("FAIL wait_state_hold: stb at 1404 for %0d cycles required 4", b1_cycles);
    else passed++;
    checks++;
    if (mem[12'h402] !== 32'h0000_BBBB) $display("FAIL evict_mem: got %h required 0000bbbb", mem[12'h402]);
    else passed++;
    hold_arm = 1'b0;
  endtask

  task automatic test_reset_mid_evict();
    logic [31:0] rd; int lat; logic twe; logic [15:0] tben; logic td;
    int n = 0;
    int b0;
    do_access(1'b1, 32'h0000_1400, 4'hF, 32'hDEAD_BEEF, rd, lat, twe, tben, td);
    checks++;
    if ({lat, tben, td} !== {32'd2, 16'h000F, 1'b1})
      $display("FAIL dirty_write: lat=%0d ben=%h dirty=%b required 2/000f/1", lat, tben, td);
    else passed++;
    bus.i_rd = 1'b1; bus.i_address = 32'h0000_1800;
    while (!(bus.o_wb_stb && bus.o_wb_wen && bus.o_wb_adr == 32'h0000_1408) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 100) $display("FAIL evict_beat2_reached: got timeout required beat at 00001408"); else passed++;
    rst = 1'b1; bus.i_rd = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({bus.o_wb_cyc, bus.o_wb_stb, bus.o_stall, bus.o_ack} !== 4'b0)
      $display("FAIL reset_mid_evict: cyc/stb/stall/ack=%b required 0000",
               {bus.o_wb_cyc, bus.o_wb_stb, bus.o_stall, bus.o_ack});
    else passed++;
    rst = 1'b0;
    b0 = log_adr.size();
    do_access(1'b0, 32'h0000_1804, 4'h0, 32'h0, rd, lat, twe, tben, td);
    checks++;
    if (rd !== 32'hAA) $display("FAIL replay_after_reset_dat: got %h required 000000aa", rd); else passed++;
    checks++;
    if ({log_adr.size() - b0, log_adr[b0], log_dat[b0], log_wen[b0]} !== {32'd8, 32'h1400, 32'hDEAD_BEEF, 1'b1})
      $display("FAIL replay_after_reset_evict: beats=%0d adr=%h dat=%h wen=%b required 8/1400/deadbeef/1",
               log_adr.size() - b0, log_adr[b0], log_dat[b0], log_wen[b0]);
    else passed++;
    checks++;
    if ({log_adr[b0+4], log_wen[b0+4], log_cti[b0+7]} !== {32'h1800, 1'b0, 3'b111})
      $display("FAIL replay_after_reset_fill: adr=%h wen=%b last_cti=%b required 1800/0/111",
               log_adr[b0+4], log_wen[b0+4], log_cti[b0+7]);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_cold_read();
    test_read_hit();
    test_write_hit();
    test_evict_fill_wait();
    test_reset_mid_evict();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
